// File: rtl/seg7_display_driver_if.sv
// Bus between the CPU output register and the 7-segment display driver.
interface seg7_display_driver_if;
    logic [7:0] dataIn;
    logic       hexMode;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    modport master (
        output dataIn, hexMode,
        input  seg, dp, an, busy
    );

    modport slave (
        input  dataIn, hexMode,
        output seg, dp, an, busy
    );
endinterface

// File: rtl/seg7_display_driver.sv
// Multiplexed 4-digit 7-segment driver: decimal (double-dabble) or hex display of an 8-bit value.
// state   | meaning
// IDLE    | watching for a new value/mode; CONVERT | 8 double-dabble steps; DONE | load digit registers
module seg7_display_driver #(
    parameter int DATA_WIDTH    = 8,
    parameter int REFRESH_COUNT = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_display_driver_if.slave  bus
);

    localparam int CNT_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    start;

    logic [DATA_WIDTH-1:0]   last_value;
    logic                    last_mode;
    logic                    pending;
    logic [DATA_WIDTH-1:0]   shift;
    logic [11:0]             bcd;
    logic [11:0]             bcd_adj;
    logic [2:0]              iter;

    logic [3:0][3:0]         digit_val;
    logic [3:0]              digit_blank;

    logic [CNT_W-1:0]        refresh_cnt;
    logic [1:0]              scan_idx;
    logic [6:0]              seg_q;
    logic [3:0]              an_q;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dataIn != last_value || bus.hexMode != last_mode || pending) begin
                    start      = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (iter == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_value  <= '0;
            last_mode   <= 1'b0;
            pending     <= 1'b1;
            shift       <= '0;
            bcd         <= '0;
            iter        <= '0;
            digit_val   <= '0;
            digit_blank <= 4'b1111;
        end else if (start) begin
            shift      <= bus.dataIn;
            bcd        <= '0;
            last_value <= bus.dataIn;
            last_mode  <= bus.hexMode;
            pending    <= 1'b0;
            iter       <= '0;
        end else if (state == CONVERT) begin
            {bcd, shift} <= {bcd_adj, shift} << 1;
            iter         <= iter + 3'd1;
        end else if (state == DONE) begin
            if (last_mode) begin
                digit_val   <= {8'h00, last_value[7:4], last_value[3:0]};
                digit_blank <= 4'b1100;
            end else begin
                digit_val      <= {4'h0, bcd[11:8], bcd[7:4], bcd[3:0]};
                digit_blank[3] <= 1'b1;
                digit_blank[2] <= (bcd[11:8] == 4'd0);
                // tens only disappears when the hundreds digit is also zero
                digit_blank[1] <= (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                digit_blank[0] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            seg_q       <= 7'b1111111;
            an_q        <= 4'b1111;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_COUNT - 1)) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (digit_blank[scan_idx]) begin
                seg_q <= 7'b1111111;
                an_q  <= 4'b1111;
            end else begin
                seg_q <= seg_code(digit_val[scan_idx]);
                an_q  <= ~(4'b0001 << scan_idx);
            end
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = (state != IDLE);

endmodule

// File: doc/seg7_display_driver.md
SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the displayed value; only 8 is supported.
REQ-002 Parameter: REFRESH_COUNT, default 50000, clock cycles each digit is lit per scan step; must be at least 2.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 Port: dataIn  input  8  value to display, driven from the CPU output register.
REQ-006 Port: hexMode  input  1  1 selects two-digit hex display; 0 selects three-digit unsigned decimal display.
REQ-007 Port: seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-008 Port: dp  output  1  decimal point, active-low; tied to 1 (off).
REQ-009 Port: an  output  4  digit anode enables, active-low; an[0] selects the rightmost digit.
REQ-010 Port: busy  output  1  high while a conversion is in progress.

Function
REQ-011 SHALL hold lastValue[7:0], lastMode and a pending flag; a conversion starts when in IDLE and (dataIn != lastValue or hexMode != lastMode or pending == 1).
REQ-012 FSM states SHALL be IDLE, CONVERT and DONE; on a start edge E0: IDLE->CONVERT, shift=dataIn, bcd=12'd0, lastValue=dataIn, lastMode=hexMode, pending=0, iteration count=0.
REQ-013 Edges E1..E8 (CONVERT) SHALL each perform one double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd,shift} left by 1; after E8, state=DONE.
REQ-014 Edge E9 (DONE) SHALL load the display digit registers and return to IDLE; latency from the start edge to the display update is 9 edges, identical in both modes.
REQ-015 busy SHALL be 1 in the cycles following E0 through E8 and 0 in IDLE.
REQ-016 Changes on dataIn or hexMode during CONVERT or DONE SHALL be ignored; they are detected by the REQ-011 compare on the first IDLE cycle after E9, so the final stable value is always displayed.
REQ-017 Decimal mode: digit2/digit1/digit0 = hundreds/tens/ones; digit3 blank; leading zeros blanked (hundreds blank if 0; tens blank if hundreds and tens are both 0); ones is never blank.
REQ-018 Hex mode: digit1 = lastValue[7:4] and digit0 = lastValue[3:0], shown 0-9 and A-F with no leading-zero blanking; digit3 and digit2 blank.
REQ-019 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 The refresh counter SHALL count 0..REFRESH_COUNT-1 and wrap; on each wrap, scan index 0->1->2->3->0.
REQ-021 For the current scan index, an SHALL drive that single bit low only if the digit is not blank; for a blank digit, an=4'b1111 and seg=7'b1111111.
REQ-022 The display registers SHALL change only on the DONE edge; seg/an are registered, with one cycle of latency from the scan index.

Reset
REQ-023 With reset=0 on an edge: state=IDLE, busy=0, seg=7'b1111111, an=4'b1111, dp=1, refresh counter=0, scan index=0, lastValue=0, lastMode=0, all digits blank, pending=1.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion at that edge; no partial result reaches the display.
REQ-025 The first edge with reset=1 SHALL start a conversion of the current dataIn, because pending=1.

Verification (REFRESH_COUNT=4)
REQ-026 reset=0 for 3 edges, dataIn=0 -> an=1111, seg=1111111, busy=0; after release, busy=1 for 9 cycles, then on scan index 0 an=1110 and seg=1000000; indices 1-3 give an=1111.
REQ-027 hexMode=0, dataIn=8'd255 -> after 9 edges, digit2/1/0 show 0100100/0010010/0010010; digit3 blank.
REQ-028 hexMode=0, dataIn=8'd7 -> only index 0 is lit (seg=1111000); indices 1-3 give an=1111.
REQ-029 hexMode=1, dataIn=8'hA5 -> digit1 seg=0001000, digit0 seg=0010010; digits 2 and 3 blank.
REQ-030 dataIn=8'd10 is converted; at E3 dataIn changes to 8'd200 -> the display shows 10 after E9, a new conversion starts at the next IDLE edge, and 200 is displayed 10 edges after E9.
REQ-031 reset=0 at E4 of a conversion -> at that edge busy=0, state=IDLE and an=1111; after release, the current dataIn is converted and displayed.
